// File: rtl/button_debouncer.sv
// Debouncer for a raw button/switch level: synchronizer plus a 4-state qualify FSM.
// Ports: clk, reset (async, active-high), key (raw pin), pressed (debounced level), busy (qualifying).
// Build option: define BUTTON_ACTIVE_LOW_EN when the board pin reads 0 while pressed.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pressed,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REL,
        PRESS_WAIT,
        PRS,
        REL_WAIT
    } state_t;

    // Normalised level: 1 always means pressed from here on.
    logic key_n;

`ifdef BUTTON_ACTIVE_LOW_EN
    assign key_n = ~key;
`else
    assign key_n = key;
`endif

    // Reset value 0 is the released level in both polarities,
    // since the inversion sits in front of the first flop.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            pressed_q;
    logic            busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            REL: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = REL;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRS: begin
                if (!s) begin
                    state_d = REL_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            REL_WAIT: begin
                if (s) begin
                    state_d = PRS;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = REL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = REL;
            end
        endcase
    end

    // Outputs are flops fed from the next-state decode, so they
    // track the state register exactly and carry no glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pressed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pressed_q <= (state_d == PRS) || (state_d == REL_WAIT);
            busy_q    <= (state_d == PRESS_WAIT) || (state_d == REL_WAIT);
        end
    end

    assign pressed = pressed_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer at default parameters.
// Vector table plus an async-reset sequence; expectations go through a scoreboard queue.
module tb_button_debouncer;

    logic clk;
    logic reset;
    logic key;
    logic pressed;
    logic busy;

    button_debouncer dut (
        .clk     (clk),
        .reset   (reset),
        .key     (key),
        .pressed (pressed),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        logic rst;
        logic k;
        logic p;
        logic b;
    } vec_t;

    typedef struct {
        int   idx;
        logic p;
        logic b;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec;
    int   n_bad;
    int   step_idx;

    function automatic logic raw(input logic k);
`ifdef BUTTON_ACTIVE_LOW_EN
        return ~k;
`else
        return k;
`endif
    endfunction

    task automatic add(input logic r, input logic k,
                       input logic p, input logic b);
        vec_t v;
        v.rst = r;
        v.k   = k;
        v.p   = p;
        v.b   = b;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic k,
                         input logic p, input logic b);
        for (int i = 0; i < n; i++) add(1'b0, k, p, b);
    endtask

    // Drive one cycle's inputs at the falling edge and queue
    // what the outputs must be just after the next rising edge.
    task automatic step(input logic r, input logic k,
                        input logic p, input logic b);
        exp_t e;
        @(negedge clk);
        reset = r;
        key   = raw(k);
        e.idx = step_idx;
        e.p   = p;
        e.b   = b;
        sb.push_back(e);
        step_idx++;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (pressed !== e.p || busy !== e.b) begin
                n_bad++;
                $display("FAIL step %0d pressed/busy got %b/%b want %b/%b",
                         e.idx, pressed, busy, e.p, e.b);
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        step_idx = 0;
        reset    = 1'b1;
        key      = raw(1'b0);

        // reset then idle
        add(1'b1, 1'b0, 1'b0, 1'b0);
        add_n(4, 1'b0, 1'b0, 1'b0);

        // press held 8 edges
        add_n(2, 1'b1, 1'b0, 1'b0);
        add_n(3, 1'b1, 1'b0, 1'b1);
        add_n(3, 1'b1, 1'b1, 1'b0);

        // release held 8 edges
        add_n(2, 1'b0, 1'b1, 1'b0);
        add_n(3, 1'b0, 1'b1, 1'b1);
        add_n(3, 1'b0, 1'b0, 1'b0);

        // 3-sample glitch is rejected
        add_n(2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1);
        add_n(2, 1'b0, 1'b0, 1'b1);
        add_n(5, 1'b0, 1'b0, 1'b0);

        // get pressed, then chatter while held
        add_n(2, 1'b1, 1'b0, 1'b0);
        add_n(3, 1'b1, 1'b0, 1'b1);
        add_n(3, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1);
        add_n(5, 1'b1, 1'b1, 1'b0);

        // synchronous-looking reset while pressed
        add(1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0);
        add_n(3, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].k, vecs[i].p, vecs[i].b);
        end

        // async reset in the middle of PRESS_WAIT
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #20;
        reset = 1'b1;
        #5;
        n_vec++;
        if (pressed !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset pressed/busy got %b/%b want 0/0",
                     pressed, busy);
        end
        #5;
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
